// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the two-digit BCD countdown sequencer.
//   - state_t     : sequencer state encoding (3 bits)
//   - DIGIT_W     : width of one BCD digit
//   - DIGIT_MAX   : largest legal digit value, also the borrow reload value
//   - clamp_digit : limits a preset nibble to DIGIT_MAX
package countdown_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    // Switch settings above 9 are not BCD; they load as 9.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v);
        return (v > DIGIT_MAX) ? DIGIT_MAX : v;
    endfunction

endpackage

// File: rtl/countdown_ctrl_btn_edge.sv
// Button conditioner: 2-FF synchroniser followed by a rising-edge detector.
// Ports:
//   CLOCK  in  system clock, rising edge
//   RESET  in  asynchronous active-high reset
//   btn    in  raw asynchronous button level
//   pulse  out one-cycle pulse per press, high in the cycle after the
//              second synchroniser stage first sees the button high
module btn_edge (
    input  logic CLOCK,
    input  logic RESET,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Driven only by flops, so the pulse is clean; a held button yields one pulse.
    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer. Loads two external down-counter digits
// from the preset switches, issues decrement / borrow-reload pulses once per
// prescaled tick, and raises a timed alarm when the count reaches 00.
// Ports:
//   CLOCK, RESET     clock (rising edge), asynchronous active-high reset
//   START, STOP      raw buttons (asynchronous levels)
//   RSW0, RSW1       preset switches, ones / tens
//   CNT0, CNT1       current digit values read back from the counters
//   LD[1:0]          one-cycle load pulse per digit, value on LDV0/LDV1
//   DEC[1:0]         one-cycle decrement pulse per digit
//   RUNNING, ALARM   status levels
// All outputs are registered.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | outputs low, prescaler cleared, waiting for START
// ST_LOAD  | single cycle, LD=11 with clamped presets on the bus
// ST_RUN   | prescaler running, one digit action per tick
// ST_PAUSE | prescaler frozen; START resumes, STOP abandons to IDLE
// ST_ALARM | ALARM high for ALARM_TICKS ticks or until a button press
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int ALARM_TICKS = 10
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic               STOP,
    input  logic [DIGIT_W-1:0] RSW0,
    input  logic [DIGIT_W-1:0] RSW1,
    input  logic [DIGIT_W-1:0] CNT0,
    input  logic [DIGIT_W-1:0] CNT1,
    output logic [1:0]         LD,
    output logic [DIGIT_W-1:0] LDV0,
    output logic [DIGIT_W-1:0] LDV1,
    output logic [1:0]         DEC,
    output logic               RUNNING,
    output logic               ALARM
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int ALM_W = $clog2(ALARM_TICKS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_TICKS - 1);

    state_t state;
    state_t state_nxt;

    logic start_p;
    logic stop_p;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    logic [ALM_W-1:0] alarm_cnt;
    logic             alarm_clr;
    logic             alarm_inc;

    logic [1:0]         ld_nxt;
    logic [1:0]         dec_nxt;
    logic [DIGIT_W-1:0] ldv0_nxt;
    logic [DIGIT_W-1:0] ldv1_nxt;

    btn_edge u_start (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .btn   (START),
        .pulse (start_p)
    );

    btn_edge u_stop (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .btn   (STOP),
        .pulse (stop_p)
    );

    assign tick = (pre_cnt == PRE_LAST) && ((state == ST_RUN) || (state == ST_ALARM));

    // Prescaler: free-runs in RUN/ALARM, holds in PAUSE so a resume keeps
    // the partial period, and restarts from zero otherwise.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pre_cnt <= '0;
        end else begin
            case (state)
                ST_RUN, ST_ALARM: pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                ST_PAUSE:         pre_cnt <= pre_cnt;
                default:          pre_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            alarm_cnt <= '0;
        end else if (alarm_clr) begin
            alarm_cnt <= '0;
        end else if (alarm_inc) begin
            alarm_cnt <= alarm_cnt + ALM_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        ld_nxt    = 2'b00;
        dec_nxt   = 2'b00;
        ldv0_nxt  = '0;
        ldv1_nxt  = '0;
        alarm_clr = 1'b0;
        alarm_inc = 1'b0;

        case (state)
            ST_IDLE: begin
                // The load pulse is registered on entry so it is visible
                // during the LOAD cycle and the counters take it at its end.
                if (start_p && !stop_p) begin
                    state_nxt = ST_LOAD;
                    ld_nxt    = 2'b11;
                    ldv0_nxt  = clamp_digit(RSW0);
                    ldv1_nxt  = clamp_digit(RSW1);
                end
            end

            ST_LOAD: begin
                state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (stop_p) begin
                    state_nxt = ST_PAUSE;
                end else if (tick) begin
                    if (CNT0 != '0) begin
                        dec_nxt = 2'b01;
                    end else if (CNT1 != '0) begin
                        // Borrow: ones digit reloads to 9 while tens steps down.
                        ld_nxt   = 2'b01;
                        ldv0_nxt = DIGIT_MAX;
                        dec_nxt  = 2'b10;
                    end else begin
                        state_nxt = ST_ALARM;
                        alarm_clr = 1'b1;
                    end
                end
            end

            ST_PAUSE: begin
                if (stop_p) begin
                    state_nxt = ST_IDLE;
                end else if (start_p) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_ALARM: begin
                if (start_p || stop_p) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    if (alarm_cnt == ALM_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        alarm_inc = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            LD      <= 2'b00;
            DEC     <= 2'b00;
            LDV0    <= '0;
            LDV1    <= '0;
            RUNNING <= 1'b0;
            ALARM   <= 1'b0;
        end else begin
            state   <= state_nxt;
            LD      <= ld_nxt;
            DEC     <= dec_nxt;
            LDV0    <= ldv0_nxt;
            LDV1    <= ldv1_nxt;
            RUNNING <= (state_nxt == ST_RUN);
            ALARM   <= (state_nxt == ST_ALARM);
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with TICK_DIV=4, ALARM_TICKS=3 and behavioural
// digit counters that load on LD and decrement on DEC.
module tb_countdown_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic       STOP  = 1'b0;
    logic [3:0] RSW0  = 4'd0;
    logic [3:0] RSW1  = 4'd0;
    logic [3:0] CNT0  = 4'd0;
    logic [3:0] CNT1  = 4'd0;
    logic [1:0] LD;
    logic [3:0] LDV0;
    logic [3:0] LDV1;
    logic [1:0] DEC;
    logic       RUNNING;
    logic       ALARM;

    int passed = 0;
    int total  = 0;

    countdown_ctrl #(.TICK_DIV(4), .ALARM_TICKS(3)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .START   (START),
        .STOP    (STOP),
        .RSW0    (RSW0),
        .RSW1    (RSW1),
        .CNT0    (CNT0),
        .CNT1    (CNT1),
        .LD      (LD),
        .LDV0    (LDV0),
        .LDV1    (LDV1),
        .DEC     (DEC),
        .RUNNING (RUNNING),
        .ALARM   (ALARM)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural digit counters.
    always @(posedge CLOCK) begin
        if (LD[0])       CNT0 <= LDV0;
        else if (DEC[0]) CNT0 <= CNT0 - 4'd1;
        if (LD[1])       CNT1 <= LDV1;
        else if (DEC[1]) CNT1 <= CNT1 - 4'd1;
    end

    typedef struct {
        logic       start;
        logic [3:0] rsw0;
        logic [3:0] rsw1;
        logic [1:0] ld;
        logic [3:0] ldv0;
        logic [3:0] ldv1;
        logic [1:0] dec;
        logic       run;
        logic       alm;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic st, input logic [1:0] ld, input logic [3:0] v0,
                                input logic [3:0] v1, input logic [1:0] dec, input logic run,
                                input logic alm, input logic [7:0] cnt);
        vec_t v;
        v.start = st; v.rsw0 = 4'd2; v.rsw1 = 4'd1;
        v.ld = ld; v.ldv0 = v0; v.ldv1 = v1; v.dec = dec;
        v.run = run; v.alm = alm; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            @(negedge CLOCK);
        end
    endtask

    function automatic logic [21:0] outs();
        return {LD, LDV1, LDV0, DEC, RUNNING, ALARM, CNT1, CNT0};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        int bad;
        int decs;

        // Scenario 1 vectors: press START from IDLE with preset 12, count 12 -> 09.
        vecs[0]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00);
        vecs[1]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00);
        vecs[2]  = mk(1, 2'b11, 2, 1, 2'b00, 0, 0, 8'h00);
        vecs[3]  = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 8'h12);
        vecs[4]  = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 8'h12);
        vecs[5]  = mk(1, 2'b00, 0, 0, 2'b00, 1, 0, 8'h12);
        vecs[6]  = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h12);
        vecs[7]  = mk(0, 2'b00, 0, 0, 2'b01, 1, 0, 8'h12);
        vecs[8]  = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h11);
        vecs[9]  = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h11);
        vecs[10] = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h11);
        vecs[11] = mk(0, 2'b00, 0, 0, 2'b01, 1, 0, 8'h11);
        vecs[12] = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h10);
        vecs[13] = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h10);
        vecs[14] = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h10);
        vecs[15] = mk(0, 2'b01, 9, 0, 2'b10, 1, 0, 8'h10);
        vecs[16] = mk(0, 2'b00, 0, 0, 2'b00, 1, 0, 8'h09);

        #1 RESET = 1'b1;
        #1 chk("reset_outputs", {10'd0, LD, LDV1, LDV0, DEC, RUNNING, ALARM}, 32'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;

        for (int i = 0; i < 17; i++) begin
            START = vecs[i].start;
            RSW0  = vecs[i].rsw0;
            RSW1  = vecs[i].rsw1;
            step(1);
            chk($sformatf("vec%0d", i), {10'd0, outs()},
                {10'd0, vecs[i].ld, vecs[i].ldv1, vecs[i].ldv0, vecs[i].dec,
                 vecs[i].run, vecs[i].alm, vecs[i].cnt});
        end

        // Scenario 2: count 09 down to 00, then alarm for 3 ticks.
        n = 0; decs = 0;
        while (!ALARM && n < 100) begin
            step(1);
            n++;
            if (DEC == 2'b01) decs++;
        end
        chk("alarm_latency", n, 39);
        chk("decs_to_zero", decs, 9);
        chk("alarm_entry_outs", {LD, DEC, RUNNING, CNT1, CNT0}, {2'b00, 2'b00, 1'b0, 8'h00});
        m = 0;
        while (ALARM && m < 50) begin
            step(1);
            m++;
        end
        chk("alarm_width", m, 12);
        chk("after_alarm_idle", {10'd0, LD, LDV1, LDV0, DEC, RUNNING, ALARM}, 32'd0);

        // Scenario 3: pause holds prescaler, resume finishes the partial period.
        RSW0 = 4'd5; RSW1 = 4'd0; START = 1'b1;
        step(3);
        chk("s3_load", {LD, LDV1, LDV0}, {2'b11, 4'd0, 4'd5});
        START = 1'b0;
        step(1);
        chk("s3_running", RUNNING, 1'b1);
        step(4);
        chk("s3_first_tick", DEC, 2'b01);
        step(2);
        STOP = 1'b1;
        step(2);
        chk("s3_tick_before_stop", {DEC, RUNNING}, {2'b01, 1'b1});
        step(1);
        chk("s3_paused", RUNNING, 1'b0);
        STOP = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (DEC != 2'b00 || LD != 2'b00 || RUNNING || ALARM) bad++;
        end
        chk("s3_pause_quiet", bad, 0);
        chk("s3_pause_cnt", CNT0, 4'd3);
        START = 1'b1;
        step(3);
        chk("s3_resumed", RUNNING, 1'b1);
        START = 1'b0;
        n = 0;
        while (DEC == 2'b00 && n < 10) begin
            step(1);
            n++;
        end
        chk("s3_resume_tick", n, 3);

        // Scenario 5: asynchronous reset between edges while running.
        @(posedge CLOCK);
        #2 RESET = 1'b1;
        #1 chk("s5_async_reset", {10'd0, LD, LDV1, LDV0, DEC, RUNNING, ALARM}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        chk("s5_cnt_untouched", CNT0, 4'd2);
        step(5);
        chk("s5_idle_after", {LD, DEC, RUNNING, ALARM}, 6'd0);

        // Scenario 4: clamped presets and simultaneous START+STOP.
        RSW0 = 4'hC; RSW1 = 4'hF; START = 1'b1;
        step(3);
        chk("s4_clamp", {LD, LDV1, LDV0}, {2'b11, 4'd9, 4'd9});
        START = 1'b0;
        step(1);
        chk("s4_running", RUNNING, 1'b1);
        START = 1'b1; STOP = 1'b1;
        step(3);
        chk("s4_both_run_pause", {RUNNING, ALARM, DEC}, 4'b0000);
        START = 1'b0; STOP = 1'b0;
        step(2);
        START = 1'b1; STOP = 1'b1;
        step(3);
        chk("s4_both_pause_idle", {RUNNING, ALARM}, 2'b00);
        START = 1'b0; STOP = 1'b0;
        step(2);
        START = 1'b1; STOP = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (LD != 2'b00 || RUNNING || ALARM) bad++;
        end
        chk("s4_both_idle_stays", bad, 0);
        START = 1'b0; STOP = 1'b0;
        step(2);
        START = 1'b1;
        step(3);
        chk("s4_reload_from_idle", {LD, LDV1, LDV0}, {2'b11, 4'd9, 4'd9});
        START = 1'b0;
        step(1);
        STOP = 1'b1;
        step(3);
        STOP = 1'b0;
        step(2);
        STOP = 1'b1;
        step(3);
        STOP = 1'b0;
        step(2);

        // Scenario 6: preset 00 alarms on first tick; STOP ends the alarm.
        RSW0 = 4'd0; RSW1 = 4'd0; START = 1'b1;
        step(3);
        chk("s6_load", {LD, LDV1, LDV0}, {2'b11, 4'd0, 4'd0});
        START = 1'b0;
        step(1);
        chk("s6_running", {RUNNING, CNT1, CNT0}, {1'b1, 8'h00});
        step(3);
        chk("s6_pre_tick", {RUNNING, ALARM}, 2'b10);
        step(1);
        chk("s6_alarm", {LD, DEC, RUNNING, ALARM}, 6'b000001);
        STOP = 1'b1;
        step(2);
        chk("s6_alarm_held", ALARM, 1'b1);
        step(1);
        chk("s6_stop_idle", {LD, DEC, RUNNING, ALARM}, 6'd0);
        STOP = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
